pla_ctrl_n: RTL and testbench
=============================

Name: pla_ctrl_n

Overview:
Parametrised successor to the three-accelerator control PLA. Decodes an opcode from a valid/ready instruction stream and sequences one of NUM_ACC accelerators through the phases READ (RAM to accelerator) and WRITE (accelerator to RAM). Drives a one-hot accelerator enable plus the RAM read/write enables, and signals completion with a one-cycle acc_done pulse. Adds behaviour the previous block lacked: abort, per-phase watchdog timeout with a sticky error flag, and illegal-opcode rejection. Sits between the instruction fetch path and the accelerator/RAM interface.

Parameters:
NUM_ACC, 3, number of accelerators; legal range 1..(2**OPCODE_W)-1
INSTR_W, 32, instruction width
OPCODE_W, 2, opcode field width, taken from instruction[OPCODE_W-1:0]
TIMEOUT_W, 16, watchdog counter width
TIMEOUT_CYCLES, 1024, maximum cycles allowed per phase; legal range 2..2**TIMEOUT_W-1

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  asynchronous, active-low reset
instruction  in  INSTR_W  instruction word
instr_valid  in  1  instruction present
instr_ready  out  1  block can accept an instruction (high only in IDLE)
read_done  in  NUM_ACC  per-accelerator read-phase complete
write_done  in  NUM_ACC  per-accelerator write-phase complete
abort  in  1  cancel the operation in progress
error_clear  in  1  clear the sticky error
acc_enable  out  NUM_ACC  one-hot enable for the selected accelerator
ram_read_enable  out  1  RAM read phase active
ram_write_enable  out  1  RAM write phase active
acc_done  out  1  one-cycle completion pulse
acc_busy  out  1  high in READ or WRITE
acc_error  out  1  sticky: timeout or illegal opcode
active_id  out  OPCODE_W  opcode of the current or last accepted operation

Behaviour:
- Reset (reset=0): takes effect immediately and asynchronously, including mid-operation. State=IDLE, counter=0, all outputs 0 except instr_ready=1, active_id=0.
- All outputs are registered or decoded from registered state; nothing is combinational from inputs.
- States: IDLE, READ, WRITE, DONE, ERROR.
- Acceptance: occurs when instr_valid & instr_ready at the rising edge. Let op = instruction[OPCODE_W-1:0].
  - op==0 (NOP): remain in IDLE; no pulse; active_id unchanged.
  - 1<=op<=NUM_ACC: go to READ; active_id<=op; selected accelerator sel = op-1.
  - op>NUM_ACC: go to ERROR; acc_error<=1.
- READ: acc_enable[sel]=1, ram_read_enable=1, acc_busy=1.
  - read_done[sel]&write_done[sel] -> DONE (WRITE is skipped).
  - read_done[sel] alone -> WRITE.
  - write_done[sel] alone -> ignored.
- WRITE: acc_enable[sel]=1, ram_write_enable=1, acc_busy=1.
  - write_done[sel] -> DONE.
- Done bits of non-selected accelerators are ignored in every state.
- DONE: lasts exactly 1 cycle. acc_done=1, all enables 0. Then IDLE.
- Latency: acceptance edge -> READ outputs visible 1 cycle later. A done sampled at edge N -> next-phase outputs visible after edge N.
- Watchdog: the counter clears on entry to READ and on entry to WRITE, and increments every cycle spent in either state.
  - If it reaches TIMEOUT_CYCLES-1 with no qualifying done -> ERROR.
  - A done arriving in that same cycle wins over the timeout.
  - The counter saturates; it never wraps.
- Abort: abort=1 in READ or WRITE -> IDLE next cycle. Enables drop, no acc_done, acc_error unchanged. Abort has priority over done and timeout. abort in IDLE, DONE or ERROR has no effect.
- ERROR: all enables 0, acc_error=1, instr_ready=0. error_clear=1 -> IDLE next cycle with acc_error<=0.
- error_clear in any other state: clears acc_error only.
- Phase enables are mutually exclusive: never ram_read_enable & ram_write_enable both high, and at most one acc_enable bit high.

Decomposition:
- pla_pkg holds:
  - state encoding localparams (ST_IDLE, ST_READ, ST_WRITE, ST_DONE, ST_ERROR; 3 bits)
  - OP_NOP=0
  - the opcode-to-one-hot decode function
- Sub-module pla_watchdog, parametrised by TIMEOUT_W and TIMEOUT_CYCLES:
  - inputs clk, reset, clear, run
  - output expired
  - saturating counter

Test Plan:
- Reset, then op=2 valid: acc_enable=3'b010 and ram_read_enable=1 one cycle later. Then read_done[1] -> ram_write_enable=1. Then write_done[1] -> acc_done high for exactly 1 cycle, then instr_ready=1.
- op=1 with read_done[0]&write_done[0] asserted together in READ -> no WRITE cycle; acc_done the next cycle. read_done[2] pulses during the op=1 run -> ignored.
- TIMEOUT_CYCLES=8, op=3, no done -> ERROR after 8 cycles in READ, acc_error=1, enables 0, instr_ready=0. error_clear -> IDLE, acc_error=0.
- abort in the 3rd WRITE cycle, with write_done asserted in that same cycle -> IDLE next cycle, acc_done never pulses.
- NUM_ACC=3, op=0 -> stays IDLE, no outputs change. Instruction with opcode field 3 under a NUM_ACC=2 build -> ERROR, acc_error=1.
- reset deasserted-to-asserted mid-WRITE, off a clock edge -> acc_enable, ram_write_enable and acc_busy all fall immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pla_pkg.sv
// Shared state encoding, opcode constants and opcode decode for the accelerator
// control PLA.
package pla_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } pla_state_t;

    localparam int unsigned OP_NOP     = 0;
    localparam int unsigned ONEHOT_MAX = 32;

    // Opcode k (k >= 1) selects accelerator k-1; NOP and out-of-range codes give no bit.
    function automatic logic [ONEHOT_MAX-1:0] op_to_onehot(input int unsigned op);
        logic [ONEHOT_MAX-1:0] result;
        result = '0;
        if (op != OP_NOP && op <= ONEHOT_MAX)
            result = ONEHOT_MAX'(1) << (op - 1);
        return result;
    endfunction

endpackage

// File: rtl/pla_watchdog.sv
// Per-phase watchdog: saturating cycle counter that flags expiry once a phase has
// lasted TIMEOUT_CYCLES cycles.
module pla_watchdog #(
    parameter int TIMEOUT_W      = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam logic [TIMEOUT_W-1:0] LIMIT = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    logic [TIMEOUT_W-1:0] count_reg;

    // Holds at LIMIT rather than wrapping, so expiry stays asserted until cleared.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (run && count_reg != LIMIT) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign expired = (count_reg == LIMIT);

endmodule

// File: rtl/pla_ctrl_n.sv
// Sequences one of NUM_ACC accelerators through RAM read and write phases, with
// abort, per-phase watchdog and illegal-opcode rejection.
module pla_ctrl_n
    import pla_pkg::*;
#(
    parameter int NUM_ACC        = 3,
    parameter int INSTR_W        = 32,
    parameter int OPCODE_W       = 2,
    parameter int TIMEOUT_W      = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [INSTR_W-1:0]  instruction,
    input  logic                instr_valid,
    output logic                instr_ready,
    input  logic [NUM_ACC-1:0]  read_done,
    input  logic [NUM_ACC-1:0]  write_done,
    input  logic                abort,
    input  logic                error_clear,
    output logic [NUM_ACC-1:0]  acc_enable,
    output logic                ram_read_enable,
    output logic                ram_write_enable,
    output logic                acc_done,
    output logic                acc_busy,
    output logic                acc_error,
    output logic [OPCODE_W-1:0] active_id
);

    pla_state_t            state_reg;
    logic                  instr_ready_reg;
    logic [NUM_ACC-1:0]    acc_enable_reg;
    logic                  ram_read_enable_reg;
    logic                  ram_write_enable_reg;
    logic                  acc_done_reg;
    logic                  acc_busy_reg;
    logic                  acc_error_reg;
    logic [OPCODE_W-1:0]   active_id_reg;

    logic [OPCODE_W-1:0]   op;
    logic [31:0]           op_u;
    logic [ONEHOT_MAX-1:0] onehot_full;
    logic [NUM_ACC-1:0]    op_onehot;
    logic [NUM_ACC-1:0]    read_hit_vec;
    logic [NUM_ACC-1:0]    write_hit_vec;
    logic                  read_hit;
    logic                  write_hit;
    logic                  wd_clear;
    logic                  wd_expired;
    logic                  unused_bits;

    assign op          = instruction[OPCODE_W-1:0];
    assign op_u        = 32'(op);
    assign onehot_full = op_to_onehot(op_u);
    assign op_onehot   = onehot_full[NUM_ACC-1:0];
    assign unused_bits = ^{instruction[INSTR_W-1:OPCODE_W], onehot_full[ONEHOT_MAX-1:NUM_ACC]};

    // acc_enable_reg doubles as the selection mask while a phase is running.
    generate
        for (genvar gi = 0; gi < NUM_ACC; gi++) begin : g_hit
            assign read_hit_vec[gi]  = read_done[gi]  & acc_enable_reg[gi];
            assign write_hit_vec[gi] = write_done[gi] & acc_enable_reg[gi];
        end
    endgenerate

    assign read_hit  = |read_hit_vec;
    assign write_hit = |write_hit_vec;

    // Counter is held at zero outside the phases and re-zeroed on the READ->WRITE step.
    assign wd_clear = ((state_reg != ST_READ) && (state_reg != ST_WRITE)) ||
                      ((state_reg == ST_READ) && read_hit);

    pla_watchdog #(
        .TIMEOUT_W      (TIMEOUT_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (wd_clear),
        .run     (acc_busy_reg),
        .expired (wd_expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg            <= ST_IDLE;
            instr_ready_reg      <= 1'b1;
            acc_enable_reg       <= '0;
            ram_read_enable_reg  <= 1'b0;
            ram_write_enable_reg <= 1'b0;
            acc_done_reg         <= 1'b0;
            acc_busy_reg         <= 1'b0;
            acc_error_reg        <= 1'b0;
            active_id_reg        <= '0;
        end else begin
            acc_done_reg <= 1'b0;
            if (error_clear)
                acc_error_reg <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    if (instr_valid && op_u != OP_NOP) begin
                        instr_ready_reg <= 1'b0;
                        if (op_u <= NUM_ACC) begin
                            state_reg           <= ST_READ;
                            active_id_reg       <= op;
                            acc_enable_reg      <= op_onehot;
                            ram_read_enable_reg <= 1'b1;
                            acc_busy_reg        <= 1'b1;
                        end else begin
                            state_reg     <= ST_ERROR;
                            acc_error_reg <= 1'b1;
                        end
                    end
                end

                ST_READ, ST_WRITE: begin
                    // Priority: abort, then done, then watchdog expiry.
                    if (abort) begin
                        state_reg            <= ST_IDLE;
                        instr_ready_reg      <= 1'b1;
                        acc_enable_reg       <= '0;
                        ram_read_enable_reg  <= 1'b0;
                        ram_write_enable_reg <= 1'b0;
                        acc_busy_reg         <= 1'b0;
                    end else if (write_hit && (state_reg == ST_WRITE || read_hit)) begin
                        state_reg            <= ST_DONE;
                        acc_done_reg         <= 1'b1;
                        acc_enable_reg       <= '0;
                        ram_read_enable_reg  <= 1'b0;
                        ram_write_enable_reg <= 1'b0;
                        acc_busy_reg         <= 1'b0;
                    end else if (state_reg == ST_READ && read_hit) begin
                        state_reg            <= ST_WRITE;
                        ram_read_enable_reg  <= 1'b0;
                        ram_write_enable_reg <= 1'b1;
                    end else if (wd_expired) begin
                        state_reg            <= ST_ERROR;
                        acc_error_reg        <= 1'b1;
                        acc_enable_reg       <= '0;
                        ram_read_enable_reg  <= 1'b0;
                        ram_write_enable_reg <= 1'b0;
                        acc_busy_reg         <= 1'b0;
                    end
                end

                ST_DONE: begin
                    state_reg       <= ST_IDLE;
                    instr_ready_reg <= 1'b1;
                end

                ST_ERROR: begin
                    if (error_clear) begin
                        state_reg       <= ST_IDLE;
                        instr_ready_reg <= 1'b1;
                    end
                end

                default: begin
                    state_reg            <= ST_IDLE;
                    instr_ready_reg      <= 1'b1;
                    acc_enable_reg       <= '0;
                    ram_read_enable_reg  <= 1'b0;
                    ram_write_enable_reg <= 1'b0;
                    acc_busy_reg         <= 1'b0;
                end
            endcase
        end
    end

    assign instr_ready      = instr_ready_reg;
    assign acc_enable       = acc_enable_reg;
    assign ram_read_enable  = ram_read_enable_reg;
    assign ram_write_enable = ram_write_enable_reg;
    assign acc_done         = acc_done_reg;
    assign acc_busy         = acc_busy_reg;
    assign acc_error        = acc_error_reg;
    assign active_id        = active_id_reg;

endmodule

// File: tb/tb_pla_ctrl_n.sv
// Directed bench for pla_ctrl_n: stimulus pushes expected completion/error events,
// a negedge monitor pops and compares them; phase outputs checked inline.
module tb_pla_ctrl_n;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instruction;
    logic        instr_valid;
    logic        instr_ready;
    logic [2:0]  read_done, write_done;
    logic        abort, error_clear;
    logic [2:0]  acc_enable;
    logic        ram_read_enable, ram_write_enable;
    logic        acc_done, acc_busy, acc_error;
    logic [1:0]  active_id;

    logic [31:0] instr2;
    logic        valid2, ready2;
    logic [1:0]  rd2, wd2, en2;
    logic        abort2, clr2;
    logic        ren2, wen2, done2, busy2, err2;
    logic [1:0]  id2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit       is_err;
        bit [1:0] id;
    } ev_t;
    ev_t exp_q[$];
    bit  err_prev = 1'b0;

    always #5 clk = ~clk;

    pla_ctrl_n #(
        .NUM_ACC(3), .INSTR_W(32), .OPCODE_W(2), .TIMEOUT_W(16), .TIMEOUT_CYCLES(8)
    ) u_dut (
        .clk(clk), .reset(reset), .instruction(instruction), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .read_done(read_done), .write_done(write_done),
        .abort(abort), .error_clear(error_clear), .acc_enable(acc_enable),
        .ram_read_enable(ram_read_enable), .ram_write_enable(ram_write_enable),
        .acc_done(acc_done), .acc_busy(acc_busy), .acc_error(acc_error),
        .active_id(active_id)
    );

    pla_ctrl_n #(
        .NUM_ACC(2), .INSTR_W(32), .OPCODE_W(2), .TIMEOUT_W(16), .TIMEOUT_CYCLES(1024)
    ) u_dut2 (
        .clk(clk), .reset(reset), .instruction(instr2), .instr_valid(valid2),
        .instr_ready(ready2), .read_done(rd2), .write_done(wd2),
        .abort(abort2), .error_clear(clr2), .acc_enable(en2),
        .ram_read_enable(ren2), .ram_write_enable(wen2),
        .acc_done(done2), .acc_busy(busy2), .acc_error(err2),
        .active_id(id2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // Monitor: every done pulse or error rise must match the next queued expectation.
    always @(negedge clk) begin
        if (!reset) begin
            err_prev = 1'b0;
        end else begin
            if (acc_done || (acc_error && !err_prev)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: got done=%0b err=%0b, required no event",
                             acc_done, acc_error);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    check("event_kind", {31'd0, acc_error && !err_prev}, {31'd0, e.is_err});
                    check("event_id", {30'd0, active_id}, {30'd0, e.id});
                end
            end
            check("phase_exclusive", {31'd0, ram_read_enable & ram_write_enable}, 32'd0);
            check("enable_onehot", {31'd0, $countones(acc_enable) > 1}, 32'd0);
            err_prev = acc_error;
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        reset = 1'b0;
        instruction = '0; instr_valid = 0; read_done = '0; write_done = '0;
        abort = 0; error_clear = 0;
        instr2 = '0; valid2 = 0; rd2 = '0; wd2 = '0; abort2 = 0; clr2 = 0;
        repeat (2) cyc();
        check("rst_ready", instr_ready, 1);
        check("rst_enable", acc_enable, 0);
        check("rst_ren", ram_read_enable, 0);
        check("rst_wen", ram_write_enable, 0);
        check("rst_done", acc_done, 0);
        check("rst_busy", acc_busy, 0);
        check("rst_error", acc_error, 0);
        check("rst_id", active_id, 0);
        check("rst_ready2", ready2, 1);
        reset = 1'b1;
        cyc();

        // op=2: READ -> WRITE -> DONE
        instruction = 32'd2; instr_valid = 1; cyc(); instr_valid = 0;
        $display("txn op=2 read/write/done");
        check("op2_enable", acc_enable, 3'b010);
        check("op2_ren", ram_read_enable, 1);
        check("op2_busy", acc_busy, 1);
        check("op2_ready", instr_ready, 0);
        check("op2_id", active_id, 2);
        cyc();
        check("op2_ren_hold", ram_read_enable, 1);
        read_done = 3'b010; cyc(); read_done = '0;
        check("op2_wen", ram_write_enable, 1);
        check("op2_ren_off", ram_read_enable, 0);
        check("op2_enable_w", acc_enable, 3'b010);
        write_done = 3'b010; exp_q.push_back('{0, 2'd2}); cyc(); write_done = '0;
        check("op2_done", acc_done, 1);
        check("op2_done_en", acc_enable, 0);
        check("op2_done_busy", acc_busy, 0);
        cyc();
        check("op2_done_pulse", acc_done, 0);
        check("op2_ready_back", instr_ready, 1);

        // op=1: both dones together skip WRITE; other accelerator's dones ignored
        instruction = 32'd1; instr_valid = 1; cyc(); instr_valid = 0;
        $display("txn op=1 skip write");
        check("op1_enable", acc_enable, 3'b001);
        read_done = 3'b100; write_done = 3'b100; cyc(); read_done = '0; write_done = '0;
        check("op1_ignore_ren", ram_read_enable, 1);
        check("op1_ignore_wen", ram_write_enable, 0);
        read_done = 3'b001; write_done = 3'b001; exp_q.push_back('{0, 2'd1});
        cyc(); read_done = '0; write_done = '0;
        check("op1_done", acc_done, 1);
        check("op1_no_write", ram_write_enable, 0);
        cyc();
        check("op1_ready", instr_ready, 1);

        // op=0: NOP
        instruction = 32'd0; instr_valid = 1; cyc(); instr_valid = 0;
        $display("txn op=0 nop");
        check("nop_ready", instr_ready, 1);
        check("nop_enable", acc_enable, 0);
        check("nop_busy", acc_busy, 0);
        check("nop_id", active_id, 1);

        // op=3 with no done: watchdog after 8 READ cycles
        exp_q.push_back('{1, 2'd3});
        instruction = 32'd3; instr_valid = 1; cyc(); instr_valid = 0;
        $display("txn op=3 timeout");
        n = 0;
        for (int g = 0; g < 30 && ram_read_enable; g++) begin
            n++;
            cyc();
        end
        check("timeout_read_cycles", n, 8);
        check("err_flag", acc_error, 1);
        check("err_enable", acc_enable, 0);
        check("err_ren", ram_read_enable, 0);
        check("err_ready", instr_ready, 0);
        check("err_busy", acc_busy, 0);
        abort = 1; cyc(); abort = 0;
        check("err_abort_noeffect", instr_ready, 0);
        check("err_abort_flag", acc_error, 1);
        error_clear = 1; cyc(); error_clear = 0;
        check("clr_ready", instr_ready, 1);
        check("clr_flag", acc_error, 0);

        // op=2: read_done on the last allowed cycle beats timeout; abort in 3rd WRITE cycle
        instruction = 32'd2; instr_valid = 1; cyc(); instr_valid = 0;
        $display("txn op=2 done-at-limit then abort");
        repeat (7) cyc();
        check("limit_still_read", ram_read_enable, 1);
        read_done = 3'b010; cyc(); read_done = '0;
        check("limit_done_wins", ram_write_enable, 1);
        check("limit_no_error", acc_error, 0);
        repeat (2) cyc();
        check("abort_pre_wen", ram_write_enable, 1);
        abort = 1; write_done = 3'b010; cyc(); abort = 0; write_done = '0;
        check("abort_ready", instr_ready, 1);
        check("abort_enable", acc_enable, 0);
        check("abort_wen", ram_write_enable, 0);
        check("abort_no_done", acc_done, 0);
        check("abort_busy", acc_busy, 0);
        cyc();
        check("abort_no_done2", acc_done, 0);

        // asynchronous reset mid-WRITE
        instruction = 32'd1; instr_valid = 1; cyc(); instr_valid = 0;
        $display("txn op=1 async reset");
        read_done = 3'b001; cyc(); read_done = '0;
        check("arst_pre_wen", ram_write_enable, 1);
        #2 reset = 1'b0;
        #1;
        check("arst_enable", acc_enable, 0);
        check("arst_wen", ram_write_enable, 0);
        check("arst_busy", acc_busy, 0);
        check("arst_ready", instr_ready, 1);
        check("arst_id", active_id, 0);
        cyc(); reset = 1'b1; cyc();

        // NUM_ACC=2 build: opcode 3 is illegal
        instr2 = 32'd3; valid2 = 1; cyc(); valid2 = 0;
        $display("txn dut2 op=3 illegal");
        check("ill_error", err2, 1);
        check("ill_ready", ready2, 0);
        check("ill_enable", en2, 0);
        check("ill_busy", busy2, 0);
        clr2 = 1; cyc(); clr2 = 0;
        check("ill_clr_error", err2, 0);
        check("ill_clr_ready", ready2, 1);
        instr2 = 32'd2; valid2 = 1; cyc(); valid2 = 0;
        $display("txn dut2 op=2");
        check("dut2_enable", en2, 2'b10);
        check("dut2_ren", ren2, 1);
        rd2 = 2'b10; wd2 = 2'b10; cyc(); rd2 = '0; wd2 = '0;
        check("dut2_done", done2, 1);
        cyc();

        check("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
